// File: rtl/gbe_udp_txgen.sv
// gbe_udp_txgen: UDP TX traffic generator with counting payload, round-robin destinations and afull backpressure
module gbe_udp_txgen #(
    parameter int          DATA_WIDTH = 8,
    parameter int          NUM_DEST   = 1,
    parameter logic [31:0] BASE_IP    = 32'hC0A84001,
    parameter logic [15:0] BASE_PORT  = 16'hBEEF,
    parameter int          LEN_WIDTH  = 12
) (
    input  logic                  app_clk,
    input  logic                  app_rst_n,
    input  logic                  cfg_enable,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [LEN_WIDTH-1:0]  cfg_gap,
    input  logic [31:0]           cfg_num_pkts,
    output logic [DATA_WIDTH-1:0] app_tx_data,
    output logic                  app_tx_dvld,
    output logic                  app_tx_eof,
    output logic [31:0]           app_tx_destip,
    output logic [15:0]           app_tx_destport,
    input  logic                  app_tx_afull,
    input  logic                  app_tx_overflow,
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_words,
    output logic [15:0]           stat_overflows,
    output logic                  busy,
    output logic                  done
);
    localparam int HW = DATA_WIDTH / 2;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t                state_q, state_d;
    logic                  afull_q, afull_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, gap_q, gap_d, gcnt_q, gcnt_d, idx_q, idx_d;
    logic [31:0]           budget_q, budget_d, sent_q, sent_d, seq_q, seq_d;
    logic [2:0]            dest_q, dest_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  dvld_q, dvld_d, eof_q, eof_d, busy_q, busy_d, done_q, done_d;
    logic [31:0]           ip_q, ip_d, pkts_q, pkts_d, words_q, words_d;
    logic [15:0]           port_q, port_d, ovf_q, ovf_d;
    logic                  last;

    assign last = idx_q == len_q - LEN_WIDTH'(1);

    // Next-state logic: packet sequencing, payload generation and status counters
    always_comb begin
        state_d  = state_q;
        afull_d  = app_tx_afull;
        len_d    = len_q;
        gap_d    = gap_q;
        gcnt_d   = gcnt_q;
        idx_d    = idx_q;
        budget_d = budget_q;
        sent_d   = sent_q;
        seq_d    = seq_q;
        dest_d   = dest_q;
        data_d   = data_q;
        dvld_d   = 1'b0;
        eof_d    = 1'b0;
        busy_d   = state_q == SEND || state_q == GAP;
        done_d   = state_q == DONE;
        ip_d     = BASE_IP + 32'(dest_q);
        port_d   = BASE_PORT + 16'(dest_q);
        pkts_d   = pkts_q + 32'(dvld_q & eof_q);
        words_d  = words_q + 32'(dvld_q);
        ovf_d    = (app_tx_overflow && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
        case (state_q)
            IDLE: if (cfg_enable) begin
                len_d    = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
                gap_d    = cfg_gap;
                budget_d = cfg_num_pkts;
                idx_d    = '0;
                sent_d   = '0;
                state_d  = SEND;
            end
            SEND: if (!afull_q) begin
                dvld_d = 1'b1;
                data_d = {HW'(seq_q), HW'(idx_q)};
                eof_d  = last;
                idx_d  = last ? '0 : idx_q + LEN_WIDTH'(1);
                if (last) begin
                    seq_d   = seq_q + 32'd1;
                    dest_d  = (dest_q == 3'(NUM_DEST - 1)) ? 3'd0 : dest_q + 3'd1;
                    sent_d  = sent_q + 32'd1;
                    gcnt_d  = gap_q;
                    state_d = (budget_q != '0 && sent_q + 32'd1 == budget_q) ? DONE :
                              (gap_q != '0) ? GAP : cfg_enable ? SEND : IDLE;
                end
            end
            GAP: begin
                gcnt_d = gcnt_q - LEN_WIDTH'(1);
                if (gcnt_q <= LEN_WIDTH'(1))
                    state_d = cfg_enable ? SEND : IDLE;
            end
            DONE: if (!cfg_enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) begin
            state_q  <= IDLE;
            afull_q  <= 1'b0;
            len_q    <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            idx_q    <= '0;
            budget_q <= '0;
            sent_q   <= '0;
            seq_q    <= '0;
            dest_q   <= '0;
            data_q   <= '0;
            dvld_q   <= 1'b0;
            eof_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ip_q     <= BASE_IP;
            port_q   <= BASE_PORT;
            pkts_q   <= '0;
            words_q  <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            afull_q  <= afull_d;
            len_q    <= len_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            idx_q    <= idx_d;
            budget_q <= budget_d;
            sent_q   <= sent_d;
            seq_q    <= seq_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
            dvld_q   <= dvld_d;
            eof_q    <= eof_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ip_q     <= ip_d;
            port_q   <= port_d;
            pkts_q   <= pkts_d;
            words_q  <= words_d;
            ovf_q    <= ovf_d;
        end
    end

    assign app_tx_data     = data_q;
    assign app_tx_dvld     = dvld_q;
    assign app_tx_eof      = eof_q;
    assign app_tx_destip   = ip_q;
    assign app_tx_destport = port_q;
    assign stat_pkts       = pkts_q;
    assign stat_words      = words_q;
    assign stat_overflows  = ovf_q;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule
